// File: rtl/bank_timing_fsm.sv
// Per-bank DRAM timing sequencer: walks one bank through activate, read, write, precharge
// and refresh phases, holding each phase for its timing parameter.
module bank_timing_fsm #(
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned TCWIDTH   = 6,
    parameter int unsigned TRCD      = 4,
    parameter int unsigned TRP       = 4,
    parameter int unsigned TCL       = 5,
    parameter int unsigned TCWL      = 4,
    parameter int unsigned BL        = 8,
    parameter int unsigned TRFC      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd,
    input  logic [ADDRWIDTH-1:0] cmd_row,
    output logic [4:0]           BankFSM,
    output logic [ADDRWIDTH-1:0] RowId,
    output logic                 busy,
    output logic                 illegal
);

    localparam int unsigned CntRange = 2 ** TCWIDTH;

    if (TRCD < 1 || TRP < 1 || TCL < 1 || TCWL < 1 || TRFC < 1 || BL < 2 || (BL % 2) != 0 ||
        TRCD > CntRange || TRP > CntRange || TCL > CntRange || TCWL > CntRange ||
        TRFC > CntRange || (BL / 2) > CntRange) begin : g_param_check
        $error("bank_timing_fsm: timing parameter out of range for TCWIDTH");
    end

    localparam logic [2:0] CmdNop = 3'b000;
    localparam logic [2:0] CmdAct = 3'b001;
    localparam logic [2:0] CmdRd  = 3'b010;
    localparam logic [2:0] CmdWr  = 3'b011;
    localparam logic [2:0] CmdPre = 3'b100;
    localparam logic [2:0] CmdRef = 3'b101;

    localparam logic [TCWIDTH-1:0] LdTrcd = TCWIDTH'(TRCD - 1);
    localparam logic [TCWIDTH-1:0] LdTrp  = TCWIDTH'(TRP - 1);
    localparam logic [TCWIDTH-1:0] LdTcl  = TCWIDTH'(TCL - 1);
    localparam logic [TCWIDTH-1:0] LdTcwl = TCWIDTH'(TCWL - 1);
    localparam logic [TCWIDTH-1:0] LdData = TCWIDTH'(BL / 2 - 1);
    localparam logic [TCWIDTH-1:0] LdTrfc = TCWIDTH'(TRFC - 1);

    typedef enum logic [4:0] {
        StIdle        = 5'b00000,
        StActivating  = 5'b00001,
        StBankActive  = 5'b00010,
        StRefreshing  = 5'b00111,
        StPrecharging = 5'b01010,
        StRdLat       = 5'b01011,
        StRdData      = 5'b01100,
        StWrLat       = 5'b10010,
        StWrData      = 5'b10011
    } state_e;

    state_e                 state_q, state_d;
    logic [TCWIDTH-1:0]     cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0]   row_q, row_d;
    logic                   busy_q, busy_d;
    logic                   illegal_q, illegal_d;
    logic                   cmd_live;
    logic                   timed;
    logic                   expired;

    assign cmd_live = cmd_valid && (cmd != CmdNop);
    assign timed    = (state_q != StIdle) && (state_q != StBankActive);
    assign expired  = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        illegal_d = 1'b0;

        // Timed states reject every command, including on their exit cycle.
        if (timed) begin
            illegal_d = cmd_live;
            if (!expired) begin
                cnt_d = cnt_q - TCWIDTH'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (cmd_live) begin
                    case (cmd)
                        CmdAct: begin
                            state_d = StActivating;
                            cnt_d   = LdTrcd;
                            row_d   = cmd_row;
                        end
                        CmdRef: begin
                            state_d = StRefreshing;
                            cnt_d   = LdTrfc;
                        end
                        CmdPre:  ;
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            StBankActive: begin
                if (cmd_live) begin
                    case (cmd)
                        CmdRd: begin
                            state_d = StRdLat;
                            cnt_d   = LdTcl;
                        end
                        CmdWr: begin
                            state_d = StWrLat;
                            cnt_d   = LdTcwl;
                        end
                        CmdPre: begin
                            state_d = StPrecharging;
                            cnt_d   = LdTrp;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            StActivating: if (expired) state_d = StBankActive;
            StRdLat: begin
                if (expired) begin
                    state_d = StRdData;
                    cnt_d   = LdData;
                end
            end
            StRdData: if (expired) state_d = StBankActive;
            StWrLat: begin
                if (expired) begin
                    state_d = StWrData;
                    cnt_d   = LdData;
                end
            end
            StWrData:      if (expired) state_d = StBankActive;
            StPrecharging: if (expired) state_d = StIdle;
            StRefreshing:  if (expired) state_d = StIdle;
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != StIdle) && (state_d != StBankActive);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            row_q     <= '0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
        end
    end

    assign BankFSM = state_q;
    assign RowId   = row_q;
    assign busy    = busy_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_bank_timing_fsm.sv
// Directed bench for bank_timing_fsm: phase durations, illegal-command pulses, async reset
// and a minimum-timing instance.
module tb_bank_timing_fsm;

    localparam logic [4:0] StIdle        = 5'b00000;
    localparam logic [4:0] StActivating  = 5'b00001;
    localparam logic [4:0] StBankActive  = 5'b00010;
    localparam logic [4:0] StRefreshing  = 5'b00111;
    localparam logic [4:0] StPrecharging = 5'b01010;
    localparam logic [4:0] StRdLat       = 5'b01011;
    localparam logic [4:0] StRdData      = 5'b01100;
    localparam logic [4:0] StWrLat       = 5'b10010;
    localparam logic [4:0] StWrData      = 5'b10011;

    localparam logic [2:0] CmdNop = 3'b000;
    localparam logic [2:0] CmdAct = 3'b001;
    localparam logic [2:0] CmdRd  = 3'b010;
    localparam logic [2:0] CmdWr  = 3'b011;
    localparam logic [2:0] CmdPre = 3'b100;
    localparam logic [2:0] CmdRef = 3'b101;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid, cmd_valid2;
    logic [2:0]  cmd, cmd2;
    logic [16:0] cmd_row, cmd_row2;
    logic [4:0]  bank_fsm, bank_fsm2;
    logic [16:0] row_id, row_id2;
    logic        busy, busy2;
    logic        illegal, illegal2;

    int checks = 0;
    int errors = 0;

    bank_timing_fsm dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_row   (cmd_row),
        .BankFSM   (bank_fsm),
        .RowId     (row_id),
        .busy      (busy),
        .illegal   (illegal)
    );

    bank_timing_fsm #(
        .TRCD (1),
        .BL   (2)
    ) dut_min (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid2),
        .cmd       (cmd2),
        .cmd_row   (cmd_row2),
        .BankFSM   (bank_fsm2),
        .RowId     (row_id2),
        .busy      (busy2),
        .illegal   (illegal2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_st(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Outputs are observed 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [16:0] row);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_row   = row;
        cycle();
        cmd_valid = 1'b0;
        cmd       = CmdNop;
    endtask

    task automatic hold(input string tag, input logic [4:0] st, input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            chk_st(tag, bank_fsm, st);
            chk_b({tag, "_busy"}, busy, b);
            chk_b({tag, "_illegal"}, illegal, 1'b0);
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = CmdNop;
        cmd_row    = '0;
        cmd_valid2 = 1'b0;
        cmd2       = CmdNop;
        cmd_row2   = '0;

        cycle();
        chk_st("rst_state", bank_fsm, StIdle);
        chk_row("rst_row", row_id, 17'h0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_illegal", illegal, 1'b0);
        #2 reset_n = 1'b1;
        cycle();
        chk_st("idle_after_rst", bank_fsm, StIdle);

        // ACT: four ACTIVATING cycles then BANKACTIVE
        send(CmdAct, 17'h1ABCD);
        chk_row("act_row", row_id, 17'h1ABCD);
        hold("act", StActivating, 4, 1'b1);
        chk_st("act_done", bank_fsm, StBankActive);
        chk_b("act_done_busy", busy, 1'b0);

        // Read then write bursts
        send(CmdRd, 17'h0);
        hold("rdlat", StRdLat, 5, 1'b1);
        hold("rddata", StRdData, 4, 1'b1);
        chk_st("rd_done", bank_fsm, StBankActive);
        send(CmdWr, 17'h0);
        hold("wrlat", StWrLat, 4, 1'b1);
        hold("wrdata", StWrData, 4, 1'b1);
        chk_st("wr_done", bank_fsm, StBankActive);

        // Precharge keeps the row, then refresh from IDLE
        send(CmdPre, 17'h0);
        hold("pre", StPrecharging, 4, 1'b1);
        chk_st("pre_done", bank_fsm, StIdle);
        chk_row("pre_row_held", row_id, 17'h1ABCD);
        send(CmdRef, 17'h0);
        hold("ref", StRefreshing, 16, 1'b1);
        chk_st("ref_done", bank_fsm, StIdle);

        // PRE in IDLE is a silent no-op
        send(CmdPre, 17'h0);
        chk_st("idle_pre_state", bank_fsm, StIdle);
        chk_b("idle_pre_illegal", illegal, 1'b0);

        // RD in IDLE is illegal
        send(CmdRd, 17'h0);
        chk_b("idle_rd_illegal", illegal, 1'b1);
        chk_st("idle_rd_state", bank_fsm, StIdle);
        cycle();
        chk_b("idle_rd_pulse_end", illegal, 1'b0);

        // ACT during ACTIVATING: rejected, row and timing unchanged
        send(CmdAct, 17'h0F0F0);
        chk_st("act2_t1", bank_fsm, StActivating);
        send(CmdAct, 17'h12345);
        chk_b("act_in_act_illegal", illegal, 1'b1);
        chk_st("act_in_act_state", bank_fsm, StActivating);
        chk_row("act_in_act_row", row_id, 17'h0F0F0);
        cycle();
        hold("act2_rest", StActivating, 2, 1'b1);
        chk_st("act2_done", bank_fsm, StBankActive);

        // Reserved encoding in BANKACTIVE
        send(3'b111, 17'h0);
        chk_b("cmd111_illegal", illegal, 1'b1);
        chk_st("cmd111_state", bank_fsm, StBankActive);
        cycle();
        chk_b("cmd111_pulse_end", illegal, 1'b0);

        // RD on the last RDDATA cycle is rejected
        send(CmdRd, 17'h0);
        hold("rdlat2", StRdLat, 5, 1'b1);
        hold("rddata2", StRdData, 3, 1'b1);
        chk_st("rddata2_last", bank_fsm, StRdData);
        send(CmdRd, 17'h0);
        chk_b("rd_exit_illegal", illegal, 1'b1);
        chk_st("rd_exit_state", bank_fsm, StBankActive);
        cycle();
        chk_b("rd_exit_pulse_end", illegal, 1'b0);
        chk_st("rd_exit_stable", bank_fsm, StBankActive);

        // Async reset mid-RDLAT with counter at 2
        send(CmdRd, 17'h0);
        cycle();
        cycle();
        chk_st("rdlat_pre_rst", bank_fsm, StRdLat);
        #2 reset_n = 1'b0;
        #1;
        chk_st("async_rst_state", bank_fsm, StIdle);
        chk_row("async_rst_row", row_id, 17'h0);
        chk_b("async_rst_busy", busy, 1'b0);
        #1 reset_n = 1'b1;
        cycle();
        chk_st("post_rst_idle", bank_fsm, StIdle);
        send(CmdAct, 17'h00ABC);
        chk_row("post_rst_row", row_id, 17'h00ABC);
        hold("post_rst_act", StActivating, 4, 1'b1);
        chk_st("post_rst_active", bank_fsm, StBankActive);

        // Minimum timing instance: TRCD=1, BL=2
        cmd_valid2 = 1'b1;
        cmd2       = CmdAct;
        cmd_row2   = 17'h00042;
        cycle();
        cmd_valid2 = 1'b0;
        cmd2       = CmdNop;
        chk_st("min_act", bank_fsm2, StActivating);
        chk_row("min_row", row_id2, 17'h00042);
        cycle();
        chk_st("min_active", bank_fsm2, StBankActive);
        cmd_valid2 = 1'b1;
        cmd2       = CmdRd;
        cycle();
        cmd_valid2 = 1'b0;
        cmd2       = CmdNop;
        for (int i = 0; i < 5; i++) begin
            chk_st("min_rdlat", bank_fsm2, StRdLat);
            cycle();
        end
        chk_st("min_rddata", bank_fsm2, StRdData);
        chk_b("min_rddata_busy", busy2, 1'b1);
        cycle();
        chk_st("min_rd_done", bank_fsm2, StBankActive);
        chk_b("min_rd_done_busy", busy2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_timing_fsm.md
Name: bank_timing_fsm

Overview:
- Per-bank DRAM timing state machine that sits directly upstream of the bank synchronisation array.
- Accepts decoded DDR commands for one bank and sequences that bank through activate, read, write, precharge and refresh phases, holding each phase for its timing parameter.
- Drives the 5-bit BankFSM state code and the latched RowId that the sync stage decodes; one instance exists per bank group/bank pair.

Parameters:
ADDRWIDTH, 17, row address width
TCWIDTH, 6, width of the internal timing down-counter
TRCD, 4, ACT-to-active cycles (>=1)
TRP, 4, precharge cycles (>=1)
TCL, 5, read CAS latency cycles (>=1)
TCWL, 4, write CAS latency cycles (>=1)
BL, 8, burst length; data phase lasts BL/2 cycles (BL even, >=2)
TRFC, 16, refresh cycles (>=1)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command strobe, single cycle
cmd  input  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF, others illegal
cmd_row  input  ADDRWIDTH  row address, sampled with ACT
BankFSM  output  5  current state code
RowId  output  ADDRWIDTH  row latched by last accepted ACT
busy  output  1  high in any timed state
illegal  output  1  one-cycle pulse, command rejected

Behaviour:
- Single clock domain; reset is asynchronous and active-low.
- Reset values: BankFSM=00000 (IDLE), RowId=0, busy=0, illegal=0, counter=0. Reset asserted in any state, including mid-burst, returns to IDLE immediately with no further outputs.
- State codes:
  - IDLE 00000
  - ACTIVATING 00001
  - BANKACTIVE 00010
  - REFRESHING 00111
  - PRECHARGING 01010
  - RDLAT 01011
  - RDDATA 01100
  - WRLAT 10010
  - WRDATA 10011
- Timed state entry loads counter=N-1, where N is that state's parameter (BL/2 for the data states). The state holds while counter!=0, decrementing each cycle; on the cycle counter==0 it transitions. Each timed state therefore lasts exactly N cycles.
- Transitions, all registered, taking effect the cycle after cmd_valid:
  - IDLE+ACT -> ACTIVATING (TRCD), RowId<=cmd_row
  - IDLE+REF -> REFRESHING (TRFC) -> IDLE
  - IDLE+PRE -> IDLE, accepted as a no-op with no pulse
  - ACTIVATING -> BANKACTIVE
  - BANKACTIVE+RD -> RDLAT (TCL) -> RDDATA (BL/2) -> BANKACTIVE
  - BANKACTIVE+WR -> WRLAT (TCWL) -> WRDATA (BL/2) -> BANKACTIVE
  - BANKACTIVE+PRE -> PRECHARGING (TRP) -> IDLE; RowId is held
- NOP never changes state.
- Any other cmd_valid with a non-NOP command produces illegal=1 the following cycle, one cycle wide, with no state, counter or RowId change. This covers any command in a timed state, RD/WR/REF/ACT where disallowed, and encodings 110/111.
- A command arriving on the exit cycle of a timed state (counter==0) is evaluated against the current timed state and is therefore illegal; the controller must wait until BankFSM shows the stable state.
- busy=1 exactly when BankFSM is not IDLE and not BANKACTIVE; it is registered alongside BankFSM.
- Counter arithmetic is unsigned TCWIDTH bits. Every parameter, and BL/2, must be <= 2**TCWIDTH; violations fail an elaboration-time assertion.
- No combinational path from inputs to outputs.

Test Plan:
1. Defaults, ACT row 0x1ABCD at t0 -> BankFSM=00001 for cycles t1..t4, 00010 at t5, RowId=0x1ABCD from t1, busy=1 over t1..t4.
2. From BANKACTIVE, RD at t0 -> 01011 for 5 cycles, 01100 for 4 cycles, 00010 at t10; then WR -> 10010 for 4 cycles, 10011 for 4 cycles, back to 00010.
3. PRE in BANKACTIVE -> 01010 for 4 cycles, then 00000, RowId still 0x1ABCD. REF in IDLE -> 00111 for 16 cycles, then 00000.
4. RD in IDLE, ACT during ACTIVATING, cmd=111 in BANKACTIVE, RD on the last RDDATA cycle -> each gives illegal=1 for exactly one cycle, BankFSM sequence unchanged versus the same run without the stray command.
5. reset_n deasserted mid-RDLAT with counter=2 -> BankFSM=00000, RowId=0, busy=0 asynchronously; after release, ACT is accepted normally.
6. Instantiate with TRCD=1, BL=2 -> ACTIVATING and RDDATA each last exactly 1 cycle.
